mem_wb_stage_reg_p: RTL and testbench

//  Parametrised MEM->WB pipeline register, successor to the fixed-width mem/wb flip-flop.

---
 rtl/mem_wb_stage_reg_p_if.sv | 39 +++
 rtl/mem_wb_stage_reg_p.sv | 115 +++++++++++
 tb/tb_mem_wb_stage_reg_p.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_reg_p_if.sv
// MEM->WB stage bus: upstream payload/exception sources, stall control, and registered WB-side outputs.
interface mem_wb_stage_reg_p_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned N_EXC   = 2,
  parameter int unsigned CAUSE_W = 1,
  parameter int unsigned CNT_W   = 16
);
  logic                    in_valid;
  logic [DATA_W-1:0]       in_data;
  logic [PC_W-1:0]         in_pc;
  logic [N_EXC-1:0]        in_exc_vec;
  logic [N_EXC*ADDR_W-1:0] in_exc_addr;
  logic                    stall;
  logic                    flush;
  logic                    exc_ack;

  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic [PC_W-1:0]         out_pc;
  logic                    out_exception;
  logic [CAUSE_W-1:0]      out_cause;
  logic [ADDR_W-1:0]       out_fault_addr;
  logic                    exc_pending;
  logic [CNT_W-1:0]        stall_count;

  modport master (
    output in_valid, in_data, in_pc, in_exc_vec, in_exc_addr, stall, flush, exc_ack,
    input  out_valid, out_data, out_pc, out_exception, out_cause, out_fault_addr,
           exc_pending, stall_count
  );

  modport slave (
    input  in_valid, in_data, in_pc, in_exc_vec, in_exc_addr, stall, flush, exc_ack,
    output out_valid, out_data, out_pc, out_exception, out_cause, out_fault_addr,
           exc_pending, stall_count
  );
endinterface

// File: rtl/mem_wb_stage_reg_p.sv
// Parametrised MEM->WB pipeline register with prioritised exception merge and
// squash-until-ack behaviour; stall > flush > capture on every edge.
module mem_wb_stage_reg_p #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned N_EXC   = 2,
  parameter int unsigned CAUSE_W = 1,
  parameter int unsigned CNT_W   = 16
) (
  input logic                clock,
  input logic                reset_n,
  mem_wb_stage_reg_p_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    RUN      = 1'b0,
    HOLD_EXC = 1'b1
  } state_t;

  state_t             state;
  logic               valid_q;
  logic [DATA_W-1:0]  data_q;
  logic [PC_W-1:0]    pc_q;
  logic               exc_q;
  logic [CAUSE_W-1:0] cause_q;
  logic [ADDR_W-1:0]  fault_addr_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic               exc_any_c;
  logic [CAUSE_W-1:0] win_cause_c;
  logic [ADDR_W-1:0]  win_addr_c;

  // Priority encoder: walk from highest index down so the lowest set source wins.
  always_comb begin
    exc_any_c   = |bus.in_exc_vec;
    win_cause_c = '0;
    win_addr_c  = '0;
    for (int i = int'(N_EXC) - 1; i >= 0; i--) begin
      if (bus.in_exc_vec[i]) begin
        win_cause_c = CAUSE_W'(i);
        win_addr_c  = bus.in_exc_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      valid_q      <= 1'b0;
      data_q       <= '0;
      pc_q         <= '0;
      exc_q        <= 1'b0;
      cause_q      <= '0;
      fault_addr_q <= '0;
      stall_cnt_q  <= '0;
    end else if (bus.stall) begin
      // Everything holds, including state; only the stall counter moves.
      if (stall_cnt_q != CNT_MAX) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end else if (bus.flush) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      pc_q         <= '0;
      exc_q        <= 1'b0;
      cause_q      <= '0;
      fault_addr_q <= '0;
    end else begin
      data_q <= bus.in_data;
      pc_q   <= bus.in_pc;
      case (state)
        RUN: begin
          if (bus.in_valid && exc_any_c) begin
            valid_q      <= 1'b1;
            exc_q        <= 1'b1;
            cause_q      <= win_cause_c;
            fault_addr_q <= win_addr_c;
            state        <= HOLD_EXC;
          end else begin
            valid_q      <= bus.in_valid;
            exc_q        <= 1'b0;
            cause_q      <= '0;
            fault_addr_q <= '0;
          end
        end
        HOLD_EXC: begin
          // Younger instructions are squashed, including the one captured on the ack edge.
          valid_q      <= 1'b0;
          exc_q        <= 1'b0;
          cause_q      <= '0;
          fault_addr_q <= '0;
          if (bus.exc_ack) begin
            state <= RUN;
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  assign bus.out_valid      = valid_q;
  assign bus.out_data       = data_q;
  assign bus.out_pc         = pc_q;
  assign bus.out_exception  = exc_q;
  assign bus.out_cause      = cause_q;
  assign bus.out_fault_addr = fault_addr_q;
  assign bus.exc_pending    = (state == HOLD_EXC);
  assign bus.stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage_reg_p.sv
// Directed bench for mem_wb_stage_reg_p: default-width instance plus a CNT_W=2 instance sharing stimulus.
module tb_mem_wb_stage_reg_p;

  logic clock;
  logic reset_n;
  int   checks;
  int   errors;

  mem_wb_stage_reg_p_if #(.CNT_W(16)) a_if ();
  mem_wb_stage_reg_p_if #(.CNT_W(2))  b_if ();

  mem_wb_stage_reg_p #(.CNT_W(16)) dut_a (.clock(clock), .reset_n(reset_n), .bus(a_if.slave));
  mem_wb_stage_reg_p #(.CNT_W(2))  dut_b (.clock(clock), .reset_n(reset_n), .bus(b_if.slave));

  assign b_if.in_valid    = a_if.in_valid;
  assign b_if.in_data     = a_if.in_data;
  assign b_if.in_pc       = a_if.in_pc;
  assign b_if.in_exc_vec  = a_if.in_exc_vec;
  assign b_if.in_exc_addr = a_if.in_exc_addr;
  assign b_if.stall       = a_if.stall;
  assign b_if.flush       = a_if.flush;
  assign b_if.exc_ack     = a_if.exc_ack;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [31:0] pc,
                       input logic [1:0] ev);
    a_if.in_valid   = v;
    a_if.in_data    = d;
    a_if.in_pc      = pc;
    a_if.in_exc_vec = ev;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    a_if.in_valid    = 1'b0;
    a_if.in_data     = '0;
    a_if.in_pc       = '0;
    a_if.in_exc_vec  = '0;
    a_if.in_exc_addr = {32'h0000_B000, 32'h0000_A000};
    a_if.stall       = 1'b0;
    a_if.flush       = 1'b0;
    a_if.exc_ack     = 1'b0;

    repeat (2) tick();
    check("rst_valid", 64'(a_if.out_valid), 64'd0);
    check("rst_pending", 64'(a_if.exc_pending), 64'd0);
    check("rst_count", 64'(a_if.stall_count), 64'd0);
    reset_n = 1'b1;

    // Clean capture
    drive(1'b1, 64'h1234, 32'h100, 2'b00);
    tick();
    check("clean_valid", 64'(a_if.out_valid), 64'd1);
    check("clean_data", a_if.out_data, 64'h1234);
    check("clean_pc", 64'(a_if.out_pc), 64'h100);
    check("clean_exc", 64'(a_if.out_exception), 64'd0);

    // Both sources fire: source 0 wins
    drive(1'b1, 64'h55, 32'h104, 2'b11);
    tick();
    check("exc_valid", 64'(a_if.out_valid), 64'd1);
    check("exc_flag", 64'(a_if.out_exception), 64'd1);
    check("exc_cause", 64'(a_if.out_cause), 64'd0);
    check("exc_addr", 64'(a_if.out_fault_addr), 64'hA000);
    check("exc_pending", 64'(a_if.exc_pending), 64'd1);

    // Squash three clean instructions while pending
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(32'h200 + i), 32'h108, 2'b00);
      tick();
      check("squash_valid", 64'(a_if.out_valid), 64'd0);
      check("squash_exc", 64'(a_if.out_exception), 64'd0);
      check("squash_pending", 64'(a_if.exc_pending), 64'd1);
    end

    // Ack edge: still squashed, then back to RUN
    a_if.exc_ack = 1'b1;
    tick();
    check("ack_valid", 64'(a_if.out_valid), 64'd0);
    check("ack_pending", 64'(a_if.exc_pending), 64'd0);
    a_if.exc_ack = 1'b0;
    drive(1'b1, 64'h77, 32'h10C, 2'b00);
    tick();
    check("post_ack_valid", 64'(a_if.out_valid), 64'd1);
    check("post_ack_data", a_if.out_data, 64'h77);

    // Only source 1 fires
    drive(1'b1, 64'h88, 32'h110, 2'b10);
    tick();
    check("src1_cause", 64'(a_if.out_cause), 64'd1);
    check("src1_addr", 64'(a_if.out_fault_addr), 64'hB000);
    drive(1'b0, 64'h0, 32'h0, 2'b00);
    a_if.exc_ack = 1'b1;
    tick();
    check("src1_exc_pulse", 64'(a_if.out_exception), 64'd0);
    check("src1_ack_pending", 64'(a_if.exc_pending), 64'd0);
    a_if.exc_ack = 1'b0;

    // Stall freezes outputs and counts
    drive(1'b1, 64'h99, 32'h114, 2'b00);
    tick();
    check("pre_stall_valid", 64'(a_if.out_valid), 64'd1);
    drive(1'b1, 64'hDEAD, 32'h118, 2'b01);
    a_if.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_data", a_if.out_data, 64'h99);
    end
    check("stall_valid", 64'(a_if.out_valid), 64'd1);
    check("stall_count5", 64'(a_if.stall_count), 64'd5);
    check("stall_sat_b", 64'(b_if.stall_count), 64'd3);
    a_if.flush = 1'b1;
    tick();
    check("stall_flush_valid", 64'(a_if.out_valid), 64'd1);
    check("stall_flush_data", a_if.out_data, 64'h99);
    check("stall_count6", 64'(a_if.stall_count), 64'd6);
    check("stall_sat_b6", 64'(b_if.stall_count), 64'd3);
    a_if.stall = 1'b0;

    // Flush in RUN with an exception request
    tick();
    check("flush_valid", 64'(a_if.out_valid), 64'd0);
    check("flush_exc", 64'(a_if.out_exception), 64'd0);
    check("flush_data", a_if.out_data, 64'd0);
    check("flush_pending", 64'(a_if.exc_pending), 64'd0);
    a_if.flush = 1'b0;
    drive(1'b1, 64'h42, 32'h11C, 2'b00);
    tick();
    check("post_flush_valid", 64'(a_if.out_valid), 64'd1);

    // Flush does not leave HOLD_EXC
    drive(1'b1, 64'h43, 32'h120, 2'b01);
    tick();
    check("hold2_exc", 64'(a_if.out_exception), 64'd1);
    a_if.flush = 1'b1;
    tick();
    check("hold_flush_pending", 64'(a_if.exc_pending), 64'd1);
    a_if.flush = 1'b0;
    drive(1'b1, 64'h44, 32'h124, 2'b00);
    tick();
    check("hold_flush_squash", 64'(a_if.out_valid), 64'd0);
    a_if.exc_ack = 1'b1;
    tick();
    a_if.exc_ack = 1'b0;

    // Re-enter HOLD_EXC, then async reset between edges
    drive(1'b1, 64'h45, 32'h128, 2'b01);
    tick();
    check("hold3_exc", 64'(a_if.out_exception), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("areset_valid", 64'(a_if.out_valid), 64'd0);
    check("areset_exc", 64'(a_if.out_exception), 64'd0);
    check("areset_data", a_if.out_data, 64'd0);
    check("areset_addr", 64'(a_if.out_fault_addr), 64'd0);
    check("areset_pending", 64'(a_if.exc_pending), 64'd0);
    check("areset_count", 64'(a_if.stall_count), 64'd0);
    check("areset_count_b", 64'(b_if.stall_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
